ascon128_aead_core: RTL and testbench
=====================================

ASCON128_AEAD_CORE -- requirements
Module: ascon128_aead_core

Interface
REQ-001 SHALL have parameter NA, default 1: number of 64-bit associated-data blocks per message, 0..255.
REQ-002 SHALL have parameter NP, default 3: number of 64-bit plaintext/ciphertext blocks per message, 0..255.
REQ-003 SHALL have parameter UNROLL, default 1: permutation rounds per cycle, one of 1, 2, 3, 6.
REQ-004 Ports SHALL be as follows:
- CLK in 1: sole clock.
- RST in 1: synchronous, active-high reset.
- START in 1: begins a message; sampled only in IDLE.
- SK in 128: key; captured on the START cycle.
- N in 128: nonce; captured on the START cycle.
- BUSY out 1: high from the cycle after START until DONE.
- DIN in 64: AD or PT block data.
- DIN_VALID in 1: input data valid.
- DIN_READY out 1: input data ready.
- DOUT out 64: ciphertext block.
- DOUT_VALID out 1: output data valid.
- DOUT_READY in 1: output data ready.
- T out 128: tag.
- DONE out 1: one-cycle pulse; T is valid from this cycle until the next START.

Function
REQ-005 SHALL implement Ascon-128 (IV 0x80400C0600000000, rate 64 bits, a=12 rounds, b=6 rounds) on full-block messages.
REQ-006 SHALL append the 10* padding block 0x8000000000000000 internally after the last AD block when NA>0, and after the last PT block always.
REQ-007 SHALL skip the whole AD phase, padding included, when NA=0, then XOR 1 into the LSB of x4 (domain separation) in every case.
REQ-008 The FSM SHALL use the states IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_OUT, PT_PERM, FINAL, DONE.
REQ-009 FSM transitions SHALL be:
- IDLE->INIT on START.
- INIT->AD_WAIT or PT_WAIT after 12/UNROLL cycles.
- AD_WAIT->AD_PERM on a DIN handshake (padding blocks need none).
- PT_WAIT->PT_OUT on a DIN handshake.
- PT_OUT->PT_PERM on a DOUT handshake.
- FINAL->DONE after 12/UNROLL cycles.
- DONE->IDLE after one cycle.
REQ-010 A 6-round permutation SHALL take 6/UNROLL cycles; the round constant SHALL be selected by a round counter, 0xF0 - 0x0F*r style, indexed from 12-a or 12-b.
REQ-011 DIN_READY SHALL be high only in AD_WAIT and PT_WAIT; a DIN_VALID outside those states SHALL be ignored and not consumed.
REQ-012 DOUT SHALL equal x0 XOR P, held stable with DOUT_VALID high in PT_OUT until DOUT_READY; the state SHALL not advance while back-pressured.
REQ-013 The final (padding) PT block SHALL produce no DOUT; FINAL SHALL XOR K into x1||x2 and T SHALL equal (x3||x4) XOR K.
REQ-014 Block counters SHALL be 8 bits; the last-block decision SHALL compare the counter to NA-1/NP-1 and SHALL not wrap.
REQ-015 START while BUSY SHALL be ignored; START in the DONE cycle SHALL be ignored.
REQ-016 SK/N changes after the START cycle SHALL have no effect on the current message.

Reset
REQ-017 With RST high at a clock edge, the FSM SHALL go to IDLE and BUSY, DIN_READY, DOUT_VALID, DONE SHALL be 0, DOUT=0, T=0, and all counters 0; this SHALL apply from any state, mid-permutation included.
REQ-018 The 320-bit state and the key register SHALL be cleared on reset.

Configuration
REQ-019 With macro ASCON_DECRYPT_EN defined, the module SHALL add input MODE (1 = decrypt, captured with START), input TAG_IN[127:0], and output TAG_OK, which is valid with DONE.
REQ-020 In decrypt mode, DOUT SHALL be plaintext (x0 XOR C), x0 SHALL be replaced by C, and TAG_OK SHALL be 1 iff T equals TAG_IN; TAG_OK SHALL reset to 0.
REQ-021 Without ASCON_DECRYPT_EN, MODE, TAG_IN and TAG_OK SHALL not exist and the module SHALL be encrypt-only.

Structure
REQ-022 Package ascon_pkg SHALL hold IV_128, the round-constant table, the padding constant, and the FSM state encoding.
REQ-023 Sub-module ascon_round SHALL be a purely combinational single round (constant add, S-box, linear layer) with the round constant as an input, instantiated UNROLL times in a chain.

Verification
REQ-024 NA=0, NP=0, key and nonce 000102..0F, START -> DONE with T=E355159F292911F794CB1432A0103A8A (NIST LWC KAT Count=1).
REQ-025 NA=1, NP=3, UNROLL=1 and 3, same key, nonce and data -> identical C and T, matching the KAT entry; UNROLL=3 DONE occurs earlier by the computed cycle count.
REQ-026 DOUT_READY held low 5 cycles on the second PT block -> DOUT stable and DIN_READY low throughout, and final T unchanged versus the no-stall run.
REQ-027 RST asserted during FINAL round 4 -> next cycle all outputs 0 and state IDLE; a following START gives the correct T.
REQ-028 START pulsed while BUSY, with DIN_VALID asserted during INIT -> both ignored, and results identical to the clean run.
REQ-029 With ASCON_DECRYPT_EN: decrypt the REQ-025 C with the correct tag -> TAG_OK=1 and DOUT equals the original P; with one flipped tag bit -> TAG_OK=0.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared Ascon-128 constants, FSM state encoding and the rotate helper.
package ascon_pkg;

  localparam logic [63:0] IV_128  = 64'h80400C0600000000;
  localparam logic [63:0] PAD_BLK = 64'h8000000000000000;

  // Round constants indexed by round number 0..11; the unused tail keeps indexing safe.
  localparam logic [7:0] RC_TABLE [16] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
    8'h78, 8'h69, 8'h5A, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [3:0] {
    ST_IDLE, ST_INIT, ST_AD_WAIT, ST_AD_PERM, ST_PT_WAIT,
    ST_PT_OUT, ST_PT_PERM, ST_FINAL, ST_DONE
  } state_t;

  // Element i holds Ascon word xi.
  typedef logic [4:0][63:0] ascon_state_t;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon128_aead_core_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t x_in,
  input  logic [7:0]   rc,
  output ascon_state_t x_out
);

  ascon_state_t a;
  ascon_state_t t;

  always_comb begin
    a    = x_in;
    a[2] = a[2] ^ {56'd0, rc};
    a[0] = a[0] ^ a[4];
    a[4] = a[4] ^ a[3];
    a[2] = a[2] ^ a[1];
    t[0] = ~a[0] & a[1];
    t[1] = ~a[1] & a[2];
    t[2] = ~a[2] & a[3];
    t[3] = ~a[3] & a[4];
    t[4] = ~a[4] & a[0];
    a[0] = a[0] ^ t[1];
    a[1] = a[1] ^ t[2];
    a[2] = a[2] ^ t[3];
    a[3] = a[3] ^ t[4];
    a[4] = a[4] ^ t[0];
    a[1] = a[1] ^ a[0];
    a[0] = a[0] ^ a[4];
    a[3] = a[3] ^ a[2];
    a[2] = ~a[2];
    x_out[0] = a[0] ^ ror64(a[0], 19) ^ ror64(a[0], 28);
    x_out[1] = a[1] ^ ror64(a[1], 61) ^ ror64(a[1], 39);
    x_out[2] = a[2] ^ ror64(a[2], 1)  ^ ror64(a[2], 6);
    x_out[3] = a[3] ^ ror64(a[3], 10) ^ ror64(a[3], 17);
    x_out[4] = a[4] ^ ror64(a[4], 7)  ^ ror64(a[4], 41);
  end

endmodule

// File: rtl/ascon128_aead_core.sv
// Ascon-128 AEAD core for full-block messages; define ASCON_DECRYPT_EN to add decryption
// (MODE, TAG_IN, TAG_OK).
module ascon128_aead_core
  import ascon_pkg::*;
#(
  parameter int NA     = 1,
  parameter int NP     = 3,
  parameter int UNROLL = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  output logic         BUSY,
  input  logic [63:0]  DIN,
  input  logic         DIN_VALID,
  output logic         DIN_READY,
  output logic [63:0]  DOUT,
  output logic         DOUT_VALID,
  input  logic         DOUT_READY,
  output logic [127:0] T,
  output logic         DONE
`ifdef ASCON_DECRYPT_EN
  ,
  input  logic         MODE,
  input  logic [127:0] TAG_IN,
  output logic         TAG_OK
`endif
);

  localparam logic [3:0] STEP     = 4'(UNROLL);
  localparam logic [3:0] LAST_RND = 4'(12 - UNROLL);
  localparam logic [3:0] B_START  = 4'd6;
  localparam logic [7:0] NA_LAST  = 8'(NA > 0 ? NA - 1 : 0);
  localparam logic [7:0] NP_LAST  = 8'(NP > 0 ? NP - 1 : 0);

  state_t       state_q, state_d;
  ascon_state_t x_q, x_d, perm_out;
  logic [127:0] key_q, key_d, t_q, t_d, tag_calc;
  logic [63:0]  dout_q, dout_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   ad_q, ad_d, pt_q, pt_d;
  logic         pad_q, pad_d, perm_last, decrypt;

`ifdef ASCON_DECRYPT_EN
  logic mode_q, mode_d, tag_ok_q, tag_ok_d;
  assign decrypt = mode_q;
  assign TAG_OK  = tag_ok_q;
`else
  assign decrypt = 1'b0;
`endif

  ascon_state_t chain [UNROLL+1];
  assign chain[0] = x_q;
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    ascon_round u_round (
      .x_in (chain[u]),
      .rc   (RC_TABLE[rnd_q + 4'(u)]),
      .x_out(chain[u+1])
    );
  end
  assign perm_out  = chain[UNROLL];
  assign perm_last = (rnd_q == LAST_RND);
  assign tag_calc  = {perm_out[3], perm_out[4]} ^ key_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    key_d   = key_q;
    t_d     = t_q;
    dout_d  = dout_q;
    rnd_d   = rnd_q;
    ad_d    = ad_q;
    pt_d    = pt_q;
    pad_d   = pad_q;
`ifdef ASCON_DECRYPT_EN
    mode_d   = mode_q;
    tag_ok_d = tag_ok_q;
`endif
    unique case (state_q)
      ST_IDLE: if (START) begin
        key_d = SK;
        x_d   = {N[63:0], N[127:64], SK[63:0], SK[127:64], IV_128};
        rnd_d = '0;
        ad_d  = '0;
        pt_d  = '0;
        pad_d = 1'b0;
`ifdef ASCON_DECRYPT_EN
        mode_d = MODE;
`endif
        state_d = ST_INIT;
      end
      ST_INIT: begin
        x_d   = perm_out;
        rnd_d = rnd_q + STEP;
        if (perm_last) begin
          x_d[3] = perm_out[3] ^ key_q[127:64];
          x_d[4] = perm_out[4] ^ key_q[63:0];
          if (NA == 0) begin
            x_d[4][0] = ~x_d[4][0];
            pad_d     = (NP == 0);
            state_d   = ST_PT_WAIT;
          end else begin
            state_d = ST_AD_WAIT;
          end
        end
      end
      ST_AD_WAIT: if (pad_q || DIN_VALID) begin
        x_d[0]  = x_q[0] ^ (pad_q ? PAD_BLK : DIN);
        rnd_d   = B_START;
        state_d = ST_AD_PERM;
      end
      ST_AD_PERM: begin
        x_d   = perm_out;
        rnd_d = rnd_q + STEP;
        if (perm_last) begin
          state_d = ST_AD_WAIT;
          if (pad_q) begin
            // AD phase closes here: domain separation, then the PT phase
            x_d[4][0] = ~perm_out[4][0];
            pad_d     = (NP == 0);
            state_d   = ST_PT_WAIT;
          end else if (ad_q == NA_LAST) begin
            pad_d = 1'b1;
          end else begin
            ad_d = ad_q + 8'd1;
          end
        end
      end
      ST_PT_WAIT: if (pad_q) begin
        x_d[0]  = x_q[0] ^ PAD_BLK;
        x_d[1]  = x_q[1] ^ key_q[127:64];
        x_d[2]  = x_q[2] ^ key_q[63:0];
        rnd_d   = '0;
        pad_d   = 1'b0;
        state_d = ST_FINAL;
      end else if (DIN_VALID) begin
        dout_d  = x_q[0] ^ DIN;
        x_d[0]  = decrypt ? DIN : x_q[0] ^ DIN;
        state_d = ST_PT_OUT;
      end
      ST_PT_OUT: if (DOUT_READY) begin
        rnd_d   = B_START;
        state_d = ST_PT_PERM;
      end
      ST_PT_PERM: begin
        x_d   = perm_out;
        rnd_d = rnd_q + STEP;
        if (perm_last) begin
          state_d = ST_PT_WAIT;
          if (pt_q == NP_LAST) pad_d = 1'b1;
          else                 pt_d  = pt_q + 8'd1;
        end
      end
      ST_FINAL: begin
        x_d   = perm_out;
        rnd_d = rnd_q + STEP;
        if (perm_last) begin
          t_d = tag_calc;
`ifdef ASCON_DECRYPT_EN
          tag_ok_d = (tag_calc == TAG_IN);
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      key_q   <= '0;
      t_q     <= '0;
      dout_q  <= '0;
      rnd_q   <= '0;
      ad_q    <= '0;
      pt_q    <= '0;
      pad_q   <= 1'b0;
`ifdef ASCON_DECRYPT_EN
      mode_q   <= 1'b0;
      tag_ok_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      key_q   <= key_d;
      t_q     <= t_d;
      dout_q  <= dout_d;
      rnd_q   <= rnd_d;
      ad_q    <= ad_d;
      pt_q    <= pt_d;
      pad_q   <= pad_d;
`ifdef ASCON_DECRYPT_EN
      mode_q   <= mode_d;
      tag_ok_q <= tag_ok_d;
`endif
    end
  end

  assign BUSY       = (state_q != ST_IDLE);
  assign DIN_READY  = (state_q == ST_AD_WAIT || state_q == ST_PT_WAIT) && !pad_q;
  assign DOUT_VALID = (state_q == ST_PT_OUT);
  assign DOUT       = dout_q;
  assign DONE       = (state_q == ST_DONE);
  assign T          = t_q;

endmodule

// File: tb/tb_ascon128_aead_core.sv
// Randomized bench for ascon128_aead_core against a table-driven Ascon model;
// define ASCON_DECRYPT_EN to also exercise decryption.
`timescale 1ns/1ps
module tb_ascon128_aead_core;

  localparam int NA = 1;
  localparam int NP = 3;
  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KAT_TAG = 128'hE355159F292911F794CB1432A0103A8A;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start, busy, din_valid, din_ready, dout_valid, dout_ready, done;
  logic [127:0] sk, nonce, tag;
  logic [63:0]  din, dout;
  logic         k_start, k_busy, k_din_ready, k_dout_valid, k_done;
  logic [127:0] k_sk, k_n, k_tag;
  logic [63:0]  k_dout;
`ifdef ASCON_DECRYPT_EN
  logic         mode, tag_ok, k_tag_ok, exp_tag_ok;
  logic [127:0] tag_in;
`endif

  ascon128_aead_core #(.NA(NA), .NP(NP), .UNROLL(1)) dut (
    .CLK(clk), .RST(rst), .START(start), .SK(sk), .N(nonce), .BUSY(busy),
    .DIN(din), .DIN_VALID(din_valid), .DIN_READY(din_ready),
    .DOUT(dout), .DOUT_VALID(dout_valid), .DOUT_READY(dout_ready),
    .T(tag), .DONE(done)
`ifdef ASCON_DECRYPT_EN
    , .MODE(mode), .TAG_IN(tag_in), .TAG_OK(tag_ok)
`endif
  );

  ascon128_aead_core #(.NA(0), .NP(0), .UNROLL(3)) dut_kat (
    .CLK(clk), .RST(rst), .START(k_start), .SK(k_sk), .N(k_n), .BUSY(k_busy),
    .DIN(64'hDEADBEEF01234567), .DIN_VALID(1'b1), .DIN_READY(k_din_ready),
    .DOUT(k_dout), .DOUT_VALID(k_dout_valid), .DOUT_READY(1'b1),
    .T(k_tag), .DONE(k_done)
`ifdef ASCON_DECRYPT_EN
    , .MODE(1'b0), .TAG_IN(128'd0), .TAG_OK(k_tag_ok)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- reference model ----------------
  logic [63:0]  m [5];
  logic [63:0]  ad_blk [4], pt_blk [4], ct_exp [4];
  logic [127:0] tag_exp;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] d = {v, v};
    return d[n +: 64];
  endfunction

  task automatic perm(input int nr);
    logic [63:0] t [5];
    logic [4:0]  c, y;
    for (int r = 12 - nr; r < 12; r++) begin
      m[2] = m[2] ^ 64'(240 - 15 * r);
      for (int j = 0; j < 64; j++) begin
        c = {m[0][j], m[1][j], m[2][j], m[3][j], m[4][j]};
        y = SBOX[c];
        t[0][j] = y[4]; t[1][j] = y[3]; t[2][j] = y[2]; t[3][j] = y[1]; t[4][j] = y[0];
      end
      m[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
      m[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
      m[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
      m[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
      m[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
    end
  endtask

  task automatic model_run(input logic [127:0] k, input logic [127:0] nn, input int na, input int np);
    m[0] = 64'h80400C0600000000; m[1] = k[127:64]; m[2] = k[63:0];
    m[3] = nn[127:64]; m[4] = nn[63:0];
    perm(12);
    m[3] ^= k[127:64]; m[4] ^= k[63:0];
    for (int i = 0; i < na; i++) begin m[0] ^= ad_blk[i]; perm(6); end
    if (na > 0) begin m[0] ^= 64'h8000000000000000; perm(6); end
    m[4] ^= 64'd1;
    for (int i = 0; i < np; i++) begin m[0] ^= pt_blk[i]; ct_exp[i] = m[0]; perm(6); end
    m[0] ^= 64'h8000000000000000; m[1] ^= k[127:64]; m[2] ^= k[63:0];
    perm(12);
    tag_exp = {m[3] ^ k[127:64], m[4] ^ k[63:0]};
  endtask

  // ---------------- drivers ----------------
  task automatic run_kat(input logic [127:0] k, input logic [127:0] nn, input logic [127:0] exp, input string nm);
    int cyc = 0;
    @(negedge clk);
    k_sk = k; k_n = nn; k_start = 1'b1;
    @(negedge clk);
    k_start = 1'b0; k_sk = rnd128(); k_n = rnd128();
    while (!k_done && cyc < 200) begin
      check({nm, "_no_dout"}, {k_dout_valid, k_din_ready}, 2'b00);
      @(negedge clk);
      cyc++;
    end
    check({nm, "_done"}, k_done, 1);
    check({nm, "_tag"}, k_tag, exp);
    check({nm, "_cycles"}, cyc, 9);
    @(negedge clk);
  endtask

  task automatic run_msg(input logic [127:0] k, input logic [127:0] nn, input bit dec,
                         input int stall_blk, input int stall_len, input bit noise,
                         input int rst_at, input int exp_cycles);
    int cyc = 0, hs = 0, oi = 0, st = 0;
    bit aborted = 0;
    logic [63:0] want;
    @(negedge clk);
    sk = k; nonce = nn; start = 1'b1;
`ifdef ASCON_DECRYPT_EN
    mode = dec;
`endif
    @(negedge clk);
    start = 1'b0; sk = rnd128(); nonce = rnd128();
`ifdef ASCON_DECRYPT_EN
    mode = ~dec;
`endif
    while (!done && cyc < 400) begin
      if (cyc == rst_at) begin
        rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_flags", {din_ready, dout_valid, done}, 3'b000);
        check("rst_dout", dout, 0);
        check("rst_tag", tag, 0);
        aborted = 1;
        break;
      end
      start = noise && (cyc == 2);
      if (start) sk = rnd128();
      if (din_ready && (!noise || $urandom_range(0, 3) != 0)) begin
        din_valid = 1'b1;
        if (hs < NA) din = ad_blk[hs];
        else         din = dec ? ct_exp[hs-NA] : pt_blk[hs-NA];
        hs++;
      end else begin
        din_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        din = {$urandom, $urandom};
      end
      dout_ready = 1'b1;
      if (dout_valid) begin
        want = dec ? pt_blk[oi] : ct_exp[oi];
        check("dout", dout, want);
        if (oi == stall_blk && st < stall_len) begin
          dout_ready = 1'b0;
          st++;
          check("stall_din_ready", din_ready, 0);
        end else begin
          oi++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; din_valid = 1'b0;
    if (!aborted) begin
      check("done", done, 1);
      check("tag", tag, tag_exp);
      check("blocks_out", oi, NP);
      if (exp_cycles > 0) check("cycles", cyc, exp_cycles);
`ifdef ASCON_DECRYPT_EN
      if (dec) check("tag_ok", tag_ok, exp_tag_ok);
`endif
      start = noise;
      @(negedge clk);
      start = 1'b0;
      check("done_pulse", done, 0);
      check("idle_after_done", busy, 0);
      check("tag_hold", tag, tag_exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, nn;
    rst = 1'b1; start = 1'b0; sk = '0; nonce = '0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    k_start = 1'b0; k_sk = '0; k_n = '0;
`ifdef ASCON_DECRYPT_EN
    mode = 1'b0; tag_in = '0; exp_tag_ok = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_flags", {busy, din_ready, dout_valid, done}, 4'b0000);
    check("reset_dout", dout, 0);
    check("reset_tag", tag, 0);
    check("reset_kat_flags", {k_busy, k_done, k_din_ready, k_dout_valid}, 4'b0000);
`ifdef ASCON_DECRYPT_EN
    check("reset_tag_ok", {tag_ok, k_tag_ok}, 2'b00);
`endif
    rst = 1'b0;

    run_kat(KAT_KEY, KAT_KEY, KAT_TAG, "kat_count1");
    for (int i = 0; i < 2; i++) begin
      k = rnd128(); nn = rnd128();
      model_run(k, nn, 0, 0);
      run_kat(k, nn, tag_exp, "kat_rand");
    end

    ad_blk[0] = 64'h0001020304050607;
    pt_blk[0] = 64'h0001020304050607;
    pt_blk[1] = 64'h08090A0B0C0D0E0F;
    pt_blk[2] = 64'h1011121314151617;
    model_run(KAT_KEY, KAT_KEY, NA, NP);
    run_msg(KAT_KEY, KAT_KEY, 1'b0, -1, 0, 1'b0, -1, 63);

    for (int i = 0; i < 3; i++) begin
      k = rnd128(); nn = rnd128();
      ad_blk[0] = {$urandom, $urandom};
      for (int j = 0; j < NP; j++) pt_blk[j] = {$urandom, $urandom};
      model_run(k, nn, NA, NP);
      run_msg(k, nn, 1'b0, -1, 0, 1'b0, -1, 63);
    end

    run_msg(k, nn, 1'b0, 1, 5, 1'b0, -1, 68);
    run_msg(k, nn, 1'b0, -1, 0, 1'b1, -1, -1);
    run_msg(k, nn, 1'b0, -1, 0, 1'b0, 54, -1);
    run_msg(k, nn, 1'b0, -1, 0, 1'b0, -1, 63);

`ifdef ASCON_DECRYPT_EN
    tag_in = tag_exp; exp_tag_ok = 1'b1;
    run_msg(k, nn, 1'b1, -1, 0, 1'b0, -1, 63);
    tag_in[$urandom_range(0, 127)] ^= 1'b1; exp_tag_ok = 1'b0;
    run_msg(k, nn, 1'b1, -1, 0, 1'b0, -1, 63);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
